host_mem_responder: RTL and testbench
=====================================

// Module: host_mem_responder
// PURPOSE
//  Memory-side responder for the accelerator's page request interface. It accepts
//  one-cycle read/write request pulses (address, 512-bit page) from the control unit.
//  It services them in order against an internal page store after a fixed latency,
//  then returns read_data/data_valid and write_done pulses. A host port preloads
//  images/programs, reads back results, and gates buffer_addr_valid.
// PARAMETERS
//  DEPTH    4096  pages in the store; valid page addresses are 0..DEPTH-1
//  LATENCY  4     service cycles per request, >=1
//  Q_DEPTH  8     request queue entries (power of 2)
// PORTS
//  clk                 in   1    clock
//  rst_n               in   1    asynchronous active-low reset
//  address             in   32   page address of request
//  write_data          in   512  page to write
//  read_request_valid  in   1    one-cycle read request pulse
//  write_request_valid in   1    one-cycle write request pulse
//  read_data           out  512  returned page, valid with data_valid
//  data_valid          out  1    one-cycle read response pulse
//  write_done          out  1    one-cycle write commit pulse
//  buffer_addr_valid   out  1    store loaded; the control unit may start fetching
//  host_we             in   1    host page write
//  host_re             in   1    host page read
//  host_addr           in   32   host page address
//  host_wdata          in   512  host write page
//  host_rdata          out  512  host read page, valid the cycle after host_re
//  cfg_go / cfg_stop   in   1    set / clear buffer_addr_valid (stop wins if both)
//  err_overflow        out  1    sticky: request arrived with queue full
//  err_both            out  1    sticky: read and write requested same cycle
//  err_oob             out  1    sticky: request/host address >= DEPTH
// BEHAVIOUR
//  Interface requirement: one clock; reset is asynchronous and active-low.
//  Reset: queue empty, state IDLE, all outputs 0 (read_data, host_rdata = 0); store not cleared.
//  No ready: every pulse is captured into the queue at the clock edge ending its cycle.
//  Both request pulses in one cycle: enqueue the write only, drop the read, set err_both.
//  Queue full, no pop that cycle: drop the request, set err_overflow.
//  Full queue with a pop that same cycle: accept the new request.
//  FSM IDLE: queue non-empty -> pop head, cnt<=LATENCY-1, go WAIT.
//  FSM WAIT: cnt!=0 -> cnt-1. cnt==0 and no host access -> service, go IDLE.
//  FSM WAIT: cnt==0 with host_we|host_re -> hold (host has priority; stall one cycle).
//  Service read: read_data<=store[addr], data_valid=1 for exactly one cycle.
//  Service write: store[addr]<=data, write_done=1 for exactly one cycle.
//  Latency, empty queue, no stalls: request in cycle T -> response pulse in cycle T+LATENCY+2.
//  Throughput: one response per LATENCY+2 cycles; strict FIFO order.
//  read_data holds its value between responses.
//  Out of range (addr>=DEPTH): read returns all zeros with data_valid; write discarded
//   but write_done still pulses; err_oob set. Host OOB access is ignored; sets err_oob.
//  Host read issued the same cycle as a host write to the same page returns the old data.
//  buffer_addr_valid: registered; set by cfg_go, cleared by cfg_stop or reset.
//  buffer_addr_valid does not gate request servicing.
//  Sticky error flags clear only on reset.
//  Reset mid-operation: pending and in-flight requests are lost; no response pulse follows.
// TESTING
//  1 Host writes page 5=A; cfg_go; read pulse addr 5 at T -> data_valid only at T+6, read_data=A.
//  2 Write pulse addr 7=B, then read addr 7 -> write_done pulse, then data_valid with B; order kept.
//  3 Ten read pulses on consecutive cycles (Q_DEPTH=8) -> 9 served in order.
//    Also for scenario 3: the 10th is dropped, err_overflow=1.
//  4 Read addr 4096 -> data_valid with 0, err_oob=1. Read and write pulsed together -> only write, err_both=1.
//  5 host_re held during the WAIT cnt==0 cycle -> response delayed 1 cycle per stalled cycle.
//    For scenario 5: host_rdata is correct the next cycle.
//  6 rst_n low while WAIT with 3 queued -> outputs 0, no pulses after release.
//    For scenario 6: store contents are preserved (host readback).

Source files
------------

// File: rtl/host_mem_responder.sv
// -----------------------------------------------------------------------------
// host_mem_responder
//
// Memory-side responder for the accelerator's page request interface. Read and
// write request pulses from the control unit are captured unconditionally into
// an in-order queue. Each request is then serviced against an internal page
// store after a fixed latency. Reads return a page with a one-cycle data_valid
// pulse and writes commit with a one-cycle write_done pulse. A host port can
// preload and read back pages, and it takes priority over request servicing.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   address               page address of a request
//   write_data            page carried by a write request
//   read_request_valid    one-cycle read request pulse
//   write_request_valid   one-cycle write request pulse
//   read_data             returned page, held between responses
//   data_valid            one-cycle read response pulse
//   write_done            one-cycle write commit pulse
//   buffer_addr_valid     store loaded flag, set by cfg_go, cleared by cfg_stop
//   host_we/host_re       host page write / read
//   host_addr             host page address
//   host_wdata            host write page
//   host_rdata            host read page, valid the cycle after host_re
//   cfg_go/cfg_stop       set / clear buffer_addr_valid (stop wins)
//   err_overflow          sticky: request dropped because the queue was full
//   err_both              sticky: read and write requested in the same cycle
//   err_oob               sticky: request or host address beyond the store
// -----------------------------------------------------------------------------
module host_mem_responder #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4,
  parameter int Q_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  address,
  input  logic [511:0] write_data,
  input  logic         read_request_valid,
  input  logic         write_request_valid,
  output logic [511:0] read_data,
  output logic         data_valid,
  output logic         write_done,
  output logic         buffer_addr_valid,
  input  logic         host_we,
  input  logic         host_re,
  input  logic [31:0]  host_addr,
  input  logic [511:0] host_wdata,
  output logic [511:0] host_rdata,
  input  logic         cfg_go,
  input  logic         cfg_stop,
  output logic         err_overflow,
  output logic         err_both,
  output logic         err_oob
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0]   DEPTH_L  = 32'(DEPTH);
  localparam logic [QW:0]   Q_FULL   = (QW + 1)'(Q_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  // Page store and request queue (no reset: contents survive reset)
  logic [511:0] r_store [DEPTH];
  logic         r_qWrite [Q_DEPTH];
  logic [31:0]  r_qAddr [Q_DEPTH];
  logic [511:0] r_qData [Q_DEPTH];

  logic [QW-1:0] r_head;
  logic [QW-1:0] r_tail;
  logic [QW:0]   r_count;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_curWrite;
  logic [31:0]   r_curAddr;
  logic [511:0]  r_curData;

  logic [511:0] r_readData;
  logic         r_dataValid;
  logic         r_writeDone;
  logic         r_bufferAddrValid;
  logic [511:0] r_hostRdata;
  logic         r_errOverflow;
  logic         r_errBoth;
  logic         r_errOob;

  logic w_hostAccess;
  logic w_hostInRange;
  logic w_curInRange;
  logic w_reqValid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_service;
  logic w_hostWrite;
  logic w_svcWrite;

  assign w_hostAccess  = host_we | host_re;
  assign w_hostInRange = host_addr < DEPTH_L;
  assign w_curInRange  = r_curAddr < DEPTH_L;
  assign w_reqValid    = read_request_valid | write_request_valid;
  assign w_full        = (r_count == Q_FULL);

  // The cycle a response pulse is out doubles as a turnaround cycle, so the
  // next pop waits one cycle and responses are spaced LATENCY+2 apart.
  assign w_pop     = (r_state == ST_IDLE) && (r_count != '0) && !(r_dataValid | r_writeDone);
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push    = w_reqValid && (!w_full || w_pop);
  // Host accesses own the store port; servicing stalls while they are present.
  assign w_service = (r_state == ST_WAIT) && (r_cnt == '0) && !w_hostAccess;

  assign w_hostWrite = host_we && w_hostInRange;
  assign w_svcWrite  = w_service && r_curWrite && w_curInRange;

  // Store write port (host and service never collide) and queue entry writes.
  // When both request pulses arrive together the write wins the slot.
  always_ff @(posedge clk) begin
    if (w_hostWrite) begin
      r_store[host_addr[AW-1:0]] <= host_wdata;
    end else if (w_svcWrite) begin
      r_store[r_curAddr[AW-1:0]] <= r_curData;
    end
    if (w_push) begin
      r_qWrite[r_tail] <= write_request_valid;
      r_qAddr[r_tail]  <= address;
      r_qData[r_tail]  <= write_data;
    end
  end

  // Queue pointers, service FSM, registered outputs and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_state           <= ST_IDLE;
      r_cnt             <= '0;
      r_curWrite        <= 1'b0;
      r_curAddr         <= '0;
      r_curData         <= '0;
      r_readData        <= '0;
      r_dataValid       <= 1'b0;
      r_writeDone       <= 1'b0;
      r_bufferAddrValid <= 1'b0;
      r_hostRdata       <= '0;
      r_errOverflow     <= 1'b0;
      r_errBoth         <= 1'b0;
      r_errOob          <= 1'b0;
    end else begin
      r_dataValid <= 1'b0;
      r_writeDone <= 1'b0;

      if (w_push) begin
        r_tail <= r_tail + QW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + QW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (QW + 1)'(1);
        2'b01:   r_count <= r_count - (QW + 1)'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_curWrite <= r_qWrite[r_head];
            r_curAddr  <= r_qAddr[r_head];
            r_curData  <= r_qData[r_head];
            r_cnt      <= CNT_INIT;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_service) begin
            r_state <= ST_IDLE;
            if (r_curWrite) begin
              r_writeDone <= 1'b1;
            end else begin
              r_dataValid <= 1'b1;
              r_readData  <= w_curInRange ? r_store[r_curAddr[AW-1:0]] : '0;
            end
            if (!w_curInRange) begin
              r_errOob <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Host read samples the store before any same-cycle host write lands.
      if (host_re && w_hostInRange) begin
        r_hostRdata <= r_store[host_addr[AW-1:0]];
      end
      if (w_hostAccess && !w_hostInRange) begin
        r_errOob <= 1'b1;
      end

      if (read_request_valid && write_request_valid) begin
        r_errBoth <= 1'b1;
      end
      if (w_reqValid && w_full && !w_pop) begin
        r_errOverflow <= 1'b1;
      end

      if (cfg_stop) begin
        r_bufferAddrValid <= 1'b0;
      end else if (cfg_go) begin
        r_bufferAddrValid <= 1'b1;
      end
    end
  end

  assign read_data         = r_readData;
  assign data_valid        = r_dataValid;
  assign write_done        = r_writeDone;
  assign buffer_addr_valid = r_bufferAddrValid;
  assign host_rdata        = r_hostRdata;
  assign err_overflow      = r_errOverflow;
  assign err_both          = r_errBoth;
  assign err_oob           = r_errOob;

endmodule

// File: tb/tb_host_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_host_mem_responder
//
// Scenario-driven bench for host_mem_responder. Each task drives one scenario
// and checks its own timing and flags; expected responses are queued when a
// request is driven and compared by the response monitor in arrival order.
// -----------------------------------------------------------------------------
module tb_host_mem_responder;

  localparam int DEPTH   = 4096;
  localparam int LATENCY = 4;
  localparam int Q_DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  address;
  logic [511:0] write_data;
  logic         read_request_valid;
  logic         write_request_valid;
  logic [511:0] read_data;
  logic         data_valid;
  logic         write_done;
  logic         buffer_addr_valid;
  logic         host_we;
  logic         host_re;
  logic [31:0]  host_addr;
  logic [511:0] host_wdata;
  logic [511:0] host_rdata;
  logic         cfg_go;
  logic         cfg_stop;
  logic         err_overflow;
  logic         err_both;
  logic         err_oob;

  typedef struct {
    logic         isWrite;
    logic [511:0] data;
  } exp_t;

  exp_t expQ[$];
  int   respCycles[$];
  exp_t monE;
  int   respCount = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  host_mem_responder #(
    .DEPTH(DEPTH),
    .LATENCY(LATENCY),
    .Q_DEPTH(Q_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .write_data(write_data),
    .read_request_valid(read_request_valid),
    .write_request_valid(write_request_valid),
    .read_data(read_data),
    .data_valid(data_valid),
    .write_done(write_done),
    .buffer_addr_valid(buffer_addr_valid),
    .host_we(host_we),
    .host_re(host_re),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .cfg_go(cfg_go),
    .cfg_stop(cfg_stop),
    .err_overflow(err_overflow),
    .err_both(err_both),
    .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (data_valid || write_done)) begin
      respCount++;
      respCycles.push_back(cyc);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_resp cycle %0d dv=%0b wd=%0b", cyc, data_valid, write_done);
      end else begin
        monE = expQ.pop_front();
        if ((write_done !== monE.isWrite) || (data_valid !== !monE.isWrite) ||
            (!monE.isWrite && (read_data !== monE.data))) begin
          errors++;
          $display("[TB] FAIL resp_match got dv=%0b wd=%0b data=%h want write=%0b data=%h",
                   data_valid, write_done, read_data, monE.isWrite, monE.data);
        end
      end
    end
  end

  function automatic logic [511:0] pageOf(input int k);
    pageOf = {16{32'(k) ^ 32'hC0DE_0000}};
  endfunction

  // Advance to the next falling edge and drop all one-cycle pulses.
  task automatic step();
    @(negedge clk);
    read_request_valid  = 1'b0;
    write_request_valid = 1'b0;
    host_we             = 1'b0;
    host_re             = 1'b0;
    cfg_go              = 1'b0;
    cfg_stop            = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({data_valid, write_done, buffer_addr_valid, err_overflow, err_both, err_oob} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 000000",
               {data_valid, write_done, buffer_addr_valid, err_overflow, err_both, err_oob});
    end
    checks++;
    if (read_data !== '0 || host_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got rd=%h hr=%h want 0", read_data, host_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_host_read_latency();
    int reqCycle;
    int target;
    respCycles.delete();
    target = respCount + 1;
    step();
    host_we = 1'b1; host_addr = 32'd5; host_wdata = pageOf(5);
    step();
    cfg_go = 1'b1;
    step();
    checks++;
    if (buffer_addr_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bav_go got %0b want 1", buffer_addr_valid);
    end
    read_request_valid = 1'b1; address = 32'd5;
    reqCycle = cyc;
    expQ.push_back('{1'b0, pageOf(5)});
    for (int i = 0; i < 40 && respCount < target; i++) step();
    checks++;
    if (respCount < target) begin
      errors++;
      $display("[TB] FAIL latency_timeout got %0d want %0d", respCount, target);
    end else begin
      checks++;
      if (respCycles[0] - reqCycle != LATENCY + 2) begin
        errors++;
        $display("[TB] FAIL read_latency got %0d want %0d", respCycles[0] - reqCycle, LATENCY + 2);
      end
    end
    step();
    cfg_go = 1'b1; cfg_stop = 1'b1;
    step();
    checks++;
    if (buffer_addr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bav_stop_wins got %0b want 0", buffer_addr_valid);
    end
  endtask

  task automatic test_write_then_read();
    int reqCycle;
    int target;
    respCycles.delete();
    target = respCount + 2;
    step();
    write_request_valid = 1'b1; address = 32'd7; write_data = pageOf(7);
    reqCycle = cyc;
    expQ.push_back('{1'b1, '0});
    step();
    read_request_valid = 1'b1; address = 32'd7;
    expQ.push_back('{1'b0, pageOf(7)});
    for (int i = 0; i < 60 && respCount < target; i++) step();
    checks++;
    if (respCount < target) begin
      errors++;
      $display("[TB] FAIL wr_rd_timeout got %0d want %0d", respCount, target);
    end else begin
      checks++;
      if (respCycles[0] - reqCycle != LATENCY + 2) begin
        errors++;
        $display("[TB] FAIL write_latency got %0d want %0d", respCycles[0] - reqCycle, LATENCY + 2);
      end
      checks++;
      if (respCycles[1] - respCycles[0] != LATENCY + 2) begin
        errors++;
        $display("[TB] FAIL throughput got %0d want %0d", respCycles[1] - respCycles[0], LATENCY + 2);
      end
    end
  endtask

  task automatic test_overflow();
    int target;
    for (int i = 0; i < 10; i++) begin
      step();
      host_we = 1'b1; host_addr = 32'(40 + i); host_wdata = pageOf(40 + i);
    end
    target = respCount + 9;
    // Holding host_re stalls the first request so the queue fills up.
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 9) begin
        checks++;
        if (err_overflow !== 1'b0) begin
          errors++;
          $display("[TB] FAIL overflow_early got %0b want 0", err_overflow);
        end
      end
      read_request_valid = 1'b1; address = 32'(40 + i);
      host_re = 1'b1; host_addr = 32'd0;
      if (i < 9) expQ.push_back('{1'b0, pageOf(40 + i)});
    end
    step();
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set got %0b want 1", err_overflow);
    end
    for (int i = 0; i < 150 && respCount < target; i++) step();
    checks++;
    if (respCount < target) begin
      errors++;
      $display("[TB] FAIL overflow_timeout got %0d want %0d", respCount, target);
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (err_overflow !== 1'b1 || err_both !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_sticky got ov=%0b both=%0b want ov=1 both=0", err_overflow, err_both);
    end
  endtask

  task automatic test_oob_both();
    int target;
    checks++;
    if (err_oob !== 1'b0 || err_both !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oob_pre got oob=%0b both=%0b want 0 0", err_oob, err_both);
    end
    target = respCount + 1;
    step();
    read_request_valid = 1'b1; address = 32'd4096;
    expQ.push_back('{1'b0, '0});
    for (int i = 0; i < 40 && respCount < target; i++) step();
    step();
    checks++;
    if (err_oob !== 1'b1) begin
      errors++;
      $display("[TB] FAIL oob_set got %0b want 1", err_oob);
    end
    target = respCount + 4;
    step();
    host_we = 1'b1; host_addr = 32'd4095; host_wdata = pageOf(4095);
    step();
    read_request_valid = 1'b1; address = 32'd4095;
    expQ.push_back('{1'b0, pageOf(4095)});
    step();
    write_request_valid = 1'b1; address = 32'd5000; write_data = pageOf(1);
    expQ.push_back('{1'b1, '0});
    step();
    read_request_valid = 1'b1; write_request_valid = 1'b1; address = 32'd20; write_data = pageOf(20);
    expQ.push_back('{1'b1, '0});
    step();
    checks++;
    if (err_both !== 1'b1) begin
      errors++;
      $display("[TB] FAIL both_set got %0b want 1", err_both);
    end
    read_request_valid = 1'b1; address = 32'd20;
    expQ.push_back('{1'b0, pageOf(20)});
    for (int i = 0; i < 80 && respCount < target; i++) step();
    checks++;
    if (respCount < target) begin
      errors++;
      $display("[TB] FAIL oob_timeout got %0d want %0d", respCount, target);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (read_data !== pageOf(20)) begin
      errors++;
      $display("[TB] FAIL read_data_hold got %h want %h", read_data, pageOf(20));
    end
  endtask

  task automatic test_host_stall();
    int reqCycle;
    int target;
    respCycles.delete();
    target = respCount + 1;
    step();
    read_request_valid = 1'b1; address = 32'd5;
    reqCycle = cyc;
    expQ.push_back('{1'b0, pageOf(5)});
    for (int i = 0; i < 5; i++) step();
    host_re = 1'b1; host_addr = 32'd5;
    step();
    checks++;
    if (host_rdata !== pageOf(5)) begin
      errors++;
      $display("[TB] FAIL host_rdata_5 got %h want %h", host_rdata, pageOf(5));
    end
    host_re = 1'b1; host_addr = 32'd7;
    step();
    checks++;
    if (host_rdata !== pageOf(7)) begin
      errors++;
      $display("[TB] FAIL host_rdata_7 got %h want %h", host_rdata, pageOf(7));
    end
    for (int i = 0; i < 40 && respCount < target; i++) step();
    checks++;
    if (respCount < target) begin
      errors++;
      $display("[TB] FAIL stall_timeout got %0d want %0d", respCount, target);
    end else begin
      checks++;
      if (respCycles[0] - reqCycle != LATENCY + 4) begin
        errors++;
        $display("[TB] FAIL stall_latency got %0d want %0d", respCycles[0] - reqCycle, LATENCY + 4);
      end
    end
    step();
    host_we = 1'b1; host_addr = 32'd30; host_wdata = pageOf(300);
    step();
    host_we = 1'b1; host_re = 1'b1; host_addr = 32'd30; host_wdata = pageOf(301);
    step();
    checks++;
    if (host_rdata !== pageOf(300)) begin
      errors++;
      $display("[TB] FAIL host_rw_old got %h want %h", host_rdata, pageOf(300));
    end
    host_re = 1'b1; host_addr = 32'd30;
    step();
    checks++;
    if (host_rdata !== pageOf(301)) begin
      errors++;
      $display("[TB] FAIL host_rw_new got %h want %h", host_rdata, pageOf(301));
    end
  endtask

  task automatic test_reset_midflight();
    int base;
    step();
    cfg_go = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      read_request_valid = 1'b1; address = (i % 2 == 0) ? 32'd5 : 32'd7;
    end
    step();
    rst_n = 1'b0;
    base = respCount;
    step();
    checks++;
    if ({data_valid, write_done, buffer_addr_valid, err_overflow, err_both, err_oob} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midreset_flags got %b want 000000",
               {data_valid, write_done, buffer_addr_valid, err_overflow, err_both, err_oob});
    end
    checks++;
    if (read_data !== '0 || host_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_data got rd=%h hr=%h want 0", read_data, host_rdata);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (respCount != base) begin
      errors++;
      $display("[TB] FAIL midreset_pulses got %0d want %0d", respCount - base, 0);
    end
    host_re = 1'b1; host_addr = 32'd5;
    step();
    checks++;
    if (host_rdata !== pageOf(5)) begin
      errors++;
      $display("[TB] FAIL preserve_5 got %h want %h", host_rdata, pageOf(5));
    end
    host_re = 1'b1; host_addr = 32'd7;
    step();
    checks++;
    if (host_rdata !== pageOf(7)) begin
      errors++;
      $display("[TB] FAIL preserve_7 got %h want %h", host_rdata, pageOf(7));
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    address             = '0;
    write_data          = '0;
    read_request_valid  = 1'b0;
    write_request_valid = 1'b0;
    host_we             = 1'b0;
    host_re             = 1'b0;
    host_addr           = '0;
    host_wdata          = '0;
    cfg_go              = 1'b0;
    cfg_stop            = 1'b0;

    test_reset();
    test_host_read_latency();
    test_write_then_read();
    test_overflow();
    test_oob_both();
    test_host_stall();
    test_reset_midflight();

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_resp got %0d outstanding want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
